// File: rtl/conv_3_3_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_3_3_window_gen_if
// Brief    : Pixel-triple input and 3x3 window output bundle for the window former.
// Revision : 1.0
// ============================================================================
interface conv_3_3_window_gen_if #(
    parameter int DATA_W = 16
);
    logic                  in_valid;
    logic [DATA_W-1:0]     row0_data;
    logic [DATA_W-1:0]     row1_data;
    logic [DATA_W-1:0]     row2_data;
    logic                  win_valid;
    logic [9*DATA_W-1:0]   win_data;
    logic                  frame_done;

    modport master (
        output in_valid, row0_data, row1_data, row2_data,
        input  win_valid, win_data, frame_done
    );

    modport slave (
        input  in_valid, row0_data, row1_data, row2_data,
        output win_valid, win_data, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/conv_3_3_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : conv_3_3_window_gen
// Brief    : Forms a registered 3x3 window per accepted pixel and flags in-image windows.
// Revision : 1.0
// ============================================================================
module conv_3_3_window_gen #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    conv_3_3_window_gen_if.slave   bus
);
    localparam int c_col_w = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_row_w = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_H - 1);
    localparam logic [c_col_w-1:0] c_col_two  = c_col_w'(2);
    localparam logic [c_row_w-1:0] c_row_two  = c_row_w'(2);

    // Element 2 is the newest column; shifting moves samples toward element 0.
    logic [2:0][DATA_W-1:0] sr0_q, sr0_d;
    logic [2:0][DATA_W-1:0] sr1_q, sr1_d;
    logic [2:0][DATA_W-1:0] sr2_q, sr2_d;
    logic [c_col_w-1:0]     col_q, col_d;
    logic [c_row_w-1:0]     row_q, row_d;
    logic [9*DATA_W-1:0]    win_data_q, win_data_d;
    logic                   win_valid_q, win_valid_d;
    logic                   frame_done_q, frame_done_d;

    always_comb begin
        sr0_d        = sr0_q;
        sr1_d        = sr1_q;
        sr2_d        = sr2_q;
        col_d        = col_q;
        row_d        = row_q;
        win_data_d   = win_data_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (flush) begin
            sr0_d      = '0;
            sr1_d      = '0;
            sr2_d      = '0;
            col_d      = '0;
            row_d      = '0;
            win_data_d = '0;
        end else if (bus.in_valid) begin
            sr2_d      = {bus.row2_data, sr2_q[2:1]};
            sr1_d      = {bus.row1_data, sr1_q[2:1]};
            sr0_d      = {bus.row0_data, sr0_q[2:1]};
            // Oldest line occupies the low-order elements k=0..2.
            win_data_d = {sr0_d, sr1_d, sr2_d};
            // Columns 0/1 hold stale samples from the previous line, so they never qualify.
            win_valid_d = (col_q >= c_col_two) && (row_q >= c_row_two);
            if (col_q == c_col_last) begin
                col_d        = '0;
                row_d        = (row_q == c_row_last) ? '0 : row_q + c_row_w'(1);
                frame_done_d = (row_q == c_row_last);
            end else begin
                col_d = col_q + c_col_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr0_q        <= '0;
            sr1_q        <= '0;
            sr2_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            win_data_q   <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sr0_q        <= sr0_d;
            sr1_q        <= sr1_d;
            sr2_q        <= sr2_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_data_q   <= win_data_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.win_data   = win_data_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
endmodule
`default_nettype wire

// File: tb/tb_conv_3_3_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_3_3_window_gen
// Brief    : Randomized self-checking bench for conv_3_3_window_gen (4x4 and 3x3 images).
// Revision : 1.0
// ============================================================================
module tb_conv_3_3_window_gen;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    conv_3_3_window_gen_if #(.DATA_W(DW)) bus4 ();
    conv_3_3_window_gen_if #(.DATA_W(DW)) bus3 ();

    conv_3_3_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(DW)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus4)
    );
    conv_3_3_window_gen #(.IMG_W(3), .IMG_H(3), .DATA_W(DW)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus3)
    );

    int errors = 0;
    int checks = 0;
    int W = 4;
    int H = 4;
    bit sel3 = 1'b0;
    bit formula = 1'b1;
    int n = 0;
    int cyc = 0;
    int img [0:3][0:3];
    int wins = 0;
    int fds = 0;
    logic [9*DW-1:0] win_q [$];
    int fd_cyc [$];
    logic [9*DW-1:0] c_first;
    logic [9*DW-1:0] c_last;

    task automatic check_eq(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] pack9(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
        int v [9];
        logic [9*DW-1:0] w;
        v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
        w = '0;
        for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(v[k]);
        return w;
    endfunction

    task automatic clear_stats();
        wins = 0;
        fds  = 0;
        win_q.delete();
        fd_cyc.delete();
    endtask

    // One clock: drive a pixel triple (or a gap/flush), then compare against the image model.
    task automatic step(input bit v, input bit fl);
        int r, c;
        bit ev, efd, gv, gfd;
        logic [9*DW-1:0] ew, gw;
        logic [DW-1:0] p0, p1, p2;
        r = n / W;
        c = n % W;
        if (n == 0) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    img[i][j] = formula ? (16 * i + j) : int'($urandom_range(0, 65535));
        end
        p0 = DW'(img[r][c]);
        p1 = (r >= 1) ? DW'(img[r-1][c]) : '0;
        p2 = (r >= 2) ? DW'(img[r-2][c]) : '0;
        bus3.in_valid = sel3 ? v : 1'b0;
        bus4.in_valid = sel3 ? 1'b0 : v;
        bus3.row0_data = p0; bus3.row1_data = p1; bus3.row2_data = p2;
        bus4.row0_data = p0; bus4.row1_data = p1; bus4.row2_data = p2;
        flush = fl;
        @(posedge clk);
        #1;
        cyc++;
        ev  = 1'b0;
        efd = 1'b0;
        ew  = '0;
        if (fl) begin
            n = 0;
        end else if (v) begin
            ev  = (r >= 2) && (c >= 2);
            efd = (r == H - 1) && (c == W - 1);
            if (ev)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew[(3*i+j)*DW +: DW] = DW'(img[r-2+i][c-2+j]);
            n = (n + 1) % (W * H);
        end
        gv  = sel3 ? bus3.win_valid  : bus4.win_valid;
        gfd = sel3 ? bus3.frame_done : bus4.frame_done;
        gw  = sel3 ? bus3.win_data   : bus4.win_data;
        check_eq("win_valid", {143'd0, gv}, {143'd0, ev});
        check_eq("frame_done", {143'd0, gfd}, {143'd0, efd});
        if (ev) check_eq("win_data", gw, ew);
        if (gv) begin
            wins++;
            win_q.push_back(gw);
        end
        if (gfd) begin
            fds++;
            fd_cyc.push_back(cyc);
        end
        flush = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        logic [9*DW-1:0] gw;
        gw = sel3 ? bus3.win_data : bus4.win_data;
        check_eq({tag, "_win_valid"}, {143'd0, sel3 ? bus3.win_valid : bus4.win_valid}, '0);
        check_eq({tag, "_frame_done"}, {143'd0, sel3 ? bus3.frame_done : bus4.frame_done}, '0);
        check_eq({tag, "_win_data"}, gw, '0);
    endtask

    initial begin
        c_first = pack9(0, 1, 2, 16, 17, 18, 32, 33, 34);
        c_last  = pack9(17, 18, 19, 33, 34, 35, 49, 50, 51);
        bus3.in_valid = 1'b0; bus3.row0_data = '0; bus3.row1_data = '0; bus3.row2_data = '0;
        bus4.in_valid = 1'b0; bus4.row0_data = '0; bus4.row1_data = '0; bus4.row2_data = '0;

        #12;
        sel3 = 1'b0; check_zero("reset4");
        sel3 = 1'b1; check_zero("reset3");
        sel3 = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Single frame, continuous
        clear_stats();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        check_eq("s1_wins", wins, 4);
        check_eq("s1_fds", fds, 1);
        check_eq("s1_first", (win_q.size() > 0) ? win_q[0] : '0, c_first);
        check_eq("s1_last", (win_q.size() > 3) ? win_q[3] : '0, c_last);

        // Alternating in_valid
        clear_stats();
        for (int i = 0; i < 32; i++) step((i % 2) == 0, 1'b0);
        check_eq("s2_wins", wins, 4);
        check_eq("s2_first", (win_q.size() > 0) ? win_q[0] : '0, c_first);
        check_eq("s2_last", (win_q.size() > 3) ? win_q[3] : '0, c_last);

        // Two frames back-to-back
        clear_stats();
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0);
        check_eq("s3_wins", wins, 8);
        check_eq("s3_fds", fds, 2);
        check_eq("s3_fd_gap", (fd_cyc.size() > 1) ? fd_cyc[1] - fd_cyc[0] : 0, 16);
        check_eq("s3_win5", (win_q.size() > 4) ? win_q[4] : '0, c_first);

        // Flush on p(2,3), then a fresh frame
        clear_stats();
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        clear_stats();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        check_eq("s4_wins", wins, 4);
        check_eq("s4_fds", fds, 1);
        check_eq("s4_first", (win_q.size() > 0) ? win_q[0] : '0, c_first);

        // Async reset mid-cycle during row 3
        clear_stats();
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        n = 0;
        clear_stats();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        check_eq("s5_wins", wins, 4);
        check_eq("s5_fds", fds, 1);

        // Random pixel data with random gaps, three frames
        formula = 1'b0;
        clear_stats();
        for (int i = 0; i < 48; i++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
        check_eq("s6_wins", wins, 12);
        check_eq("s6_fds", fds, 3);

        // 3x3 corner
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        sel3 = 1'b1; W = 3; H = 3; n = 0; formula = 1'b1;
        clear_stats();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        check_eq("s7_wins", wins, 1);
        check_eq("s7_fds", fds, 1);
        check_eq("s7_win", (win_q.size() > 0) ? win_q[0] : '0, c_first);

        formula = 1'b0;
        clear_stats();
        for (int i = 0; i < 18; i++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
        check_eq("s8_wins", wins, 2);
        check_eq("s8_fds", fds, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/conv_3_3_window_gen.md
# conv_3_3_window_gen

Stencil window former for the 3x3 convolution pipeline. It sits directly downstream of the two long-delay memtiles, which supply the one-line and two-line delayed pixel streams. The block combines those two delayed streams with the live pixel stream into a registered 3x3 window per accepted pixel. It uses column and row counters to mark which windows are fully inside the image, so downstream MAC logic only sees legal windows.

## Interface
Parameters:
- IMG_W, 64, image width in pixels; legal range 3 to 65535.
- IMG_H, 64, image height in lines; legal range 3 to 65535.
- DATA_W, 16, pixel width in bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous frame restart; same clearing effect as reset, applied at the clock edge.
- in_valid  input  1  the current-cycle pixel triple is valid and is consumed this cycle; there is no backpressure.
- row0_data  input  DATA_W  live pixel p(r,c).
- row1_data  input  DATA_W  memtile output p(r-1,c); don't-care when r<1.
- row2_data  input  DATA_W  memtile output p(r-2,c); don't-care when r<2.
- win_valid  output  1  win_data holds a complete in-image window.
- win_data  output  9 x DATA_W  packed window; element k=3*i+j holds row i (0 = oldest line, from row2_data) and column j (0 = leftmost/oldest).
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Shift registers: three 3-deep registers (sr2, sr1, sr0), one per row stream.
  - On each in_valid cycle, every register shifts left and loads its new sample into column 2. sr2 takes row2_data, sr1 takes row1_data, sr0 takes row0_data.
  - With in_valid low, all registers hold.
- Counters: col counts 0..IMG_W-1 and row counts 0..IMG_H-1. Each is $clog2 of its bound wide, minimum 1 bit.
  - Both are indexed to the pixel being accepted.
  - On accept, col increments. At col==IMG_W-1, col wraps to 0 and row increments.
  - At row==IMG_H-1 with col==IMG_W-1, both wrap to 0 (start of next frame).
- Window qualification: an accepted pixel produces a valid window iff col>=2 and row>=2, evaluated on the pre-increment counter values.
- Output registers:
  - win_data is driven from the post-shift register contents: sr2 fills k=0..2, sr1 fills k=3..5, sr0 fills k=6..8.
  - win_data updates only on in_valid cycles and otherwise holds its last value.
  - win_valid registers the qualification result on in_valid cycles and is 0 on cycles without in_valid.
- frame_done is registered. It is 1 for exactly the cycle after the accept of pixel (IMG_H-1, IMG_W-1), else 0.
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- Row-start columns 0 and 1 never produce valid windows, so stale samples left from the previous line never leak into an output.
- Reset (rst_n low, async): col, row, all shift registers, win_data, win_valid and frame_done go to 0 immediately.
- flush high at an edge: same clearing as reset, and it takes priority over in_valid in that cycle (the pixel is dropped). The next accepted pixel is treated as (0,0).
- Reset or flush mid-frame abandons the partial frame. No frame_done is produced for it.

## Timing
- Latency from accepting pixel p(r,c) to its window on win_data/win_valid: 1 cycle.
- Throughput: one pixel per cycle. Arbitrary in_valid gaps are allowed and only stretch the timing; they never change window contents.
- frame_done and the final window's win_valid are asserted in the same cycle.
- Across a frame boundary with back-to-back in_valid, there is no dead cycle: pixel (0,0) of the next frame is accepted in the cycle right after (IMG_H-1, IMG_W-1).
- Release of rst_n is synchronous to clk. The first accept can happen on the first edge after release.

## Test plan
All scenarios use IMG_W=4, IMG_H=4 and pixel value p(r,c)=16r+c. row1 and row2 are driven with 0 when out of range.

- Single frame, continuous in_valid (16 cycles) → exactly 4 win_valid pulses.
  - First pulse is one cycle after accepting p(2,2); win_data k0..k8 = 0,1,2,16,17,18,32,33,34.
  - Last window = 17,18,19,33,34,35,49,50,51, coincident with frame_done.
- Same frame with in_valid toggled 1-0-1-0 → identical 4 windows with identical contents; win_valid is never high in a cycle that follows an in_valid=0 cycle.
- Two frames back-to-back (32 cycles) → 8 windows and 2 frame_done pulses, 16 cycles apart; the 5th window again equals 0,1,2,16,17,18,32,33,34.
- flush asserted together with in_valid on p(2,3) → that pixel is not accepted, and win_valid/frame_done are 0 on the next cycle; a fresh 16-pixel frame then yields exactly 4 correct windows.
- rst_n pulsed low asynchronously mid-cycle during row 3 → all outputs read 0 before the next clk edge; a fresh frame after release yields 4 correct windows and a single frame_done.
- Parameter corner IMG_W=3, IMG_H=3 → exactly 1 window (0,1,2,16,17,18,32,33,34), coincident with frame_done.
